// File: rtl/alu.sv
// 8-bit registered ALU: sixteen operations selected by Sel, with the result and
// the carry-out of A+B captured together one clock after the operands are sampled.
module alu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [3:0] Sel,
    output logic [7:0] ALU_Out,
    output logic       Cout
);

    logic [7:0]  result_next;
    logic [7:0]  result_reg;
    logic        carry_reg;
    logic [8:0]  sum_wide;
    logic [15:0] product;
    logic [7:0]  rotl;
    logic [7:0]  rotr;

    assign sum_wide = {1'b0, A} + {1'b0, B};
    assign product  = A * B;

    // Rotations are pure rewiring; each output bit picks its neighbour with wrap.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            assign rotl[gi] = A[(gi + 7) % 8];
            assign rotr[gi] = A[(gi + 1) % 8];
        end
    endgenerate

    always_comb begin
        result_next = 8'h00;
        case (Sel)
            4'd0:  result_next = sum_wide[7:0];
            4'd1:  result_next = A - B;
            4'd2:  result_next = product[7:0];
            // Divide by zero saturates to all-ones instead of producing X.
            4'd3:  result_next = (B == 8'h00) ? 8'hFF : A / B;
            4'd4:  result_next = {A[6:0], 1'b0};
            4'd5:  result_next = {1'b0, A[7:1]};
            4'd6:  result_next = rotl;
            4'd7:  result_next = rotr;
            4'd8:  result_next = A & B;
            4'd9:  result_next = A | B;
            4'd10: result_next = A ^ B;
            4'd11: result_next = ~(A | B);
            4'd12: result_next = ~(A & B);
            4'd13: result_next = ~(A ^ B);
            4'd14: result_next = (A > B) ? 8'h01 : 8'h00;
            4'd15: result_next = (A == B) ? 8'h01 : 8'h00;
            default: result_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg <= 8'h00;
            carry_reg  <= 1'b0;
        end else begin
            result_reg <= result_next;
            carry_reg  <= sum_wide[8];
        end
    end

    assign ALU_Out = result_reg;
    assign Cout    = carry_reg;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors from the operation table plus
// random back-to-back traffic compared against an integer-arithmetic model.
`timescale 1ns/1ps
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] Sel;
    logic [7:0] ALU_Out;
    logic       Cout;

    int compared   = 0;
    int mismatched = 0;

    alu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .Sel     (Sel),
        .ALU_Out (ALU_Out),
        .Cout    (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("FAIL %s: got %02h expected %02h", tag, observed, expected);
        end
    endtask

    // Reference result from plain integer arithmetic on the operation table.
    function automatic int model_out(input int a, input int b, input int sel);
        case (sel)
            0:  return (a + b) % 256;
            1:  return (a - b + 256) % 256;
            2:  return (a * b) % 256;
            3:  return (b == 0) ? 255 : a / b;
            4:  return (a * 2) % 256;
            5:  return a / 2;
            6:  return (a * 2) % 256 + a / 128;
            7:  return a / 2 + (a % 2) * 128;
            8:  return a & b;
            9:  return a | b;
            10: return a ^ b;
            11: return 255 - (a | b);
            12: return 255 - (a & b);
            13: return 255 - (a ^ b);
            14: return (a > b) ? 1 : 0;
            default: return (a == b) ? 1 : 0;
        endcase
    endfunction

    function automatic int model_cout(input int a, input int b);
        return (a + b > 255) ? 1 : 0;
    endfunction

    // Drive on the falling edge, check 1 ns after the capturing rising edge.
    task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                         input logic [7:0] exp_out, input logic exp_cout, input string tag);
        @(negedge clk);
        A = a; B = b; Sel = sel;
        @(posedge clk);
        #1;
        check({tag, ".out"}, ALU_Out, exp_out);
        check({tag, ".cout"}, {7'd0, Cout}, {7'd0, exp_cout});
        $display("txn %s A=%02h B=%02h Sel=%0d -> out=%02h cout=%0b", tag, a, b, sel, ALU_Out, Cout);
    endtask

    initial begin
        logic [7:0] sweep_exp [16];
        logic [7:0] ra, rb;
        logic [3:0] rs;

        sweep_exp = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                      8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};

        // Reset held with all-ones operands: outputs must stay zero.
        rst_n = 1'b0; A = 8'hFF; B = 8'hFF; Sel = 4'd0;
        #1;
        check("reset.out0", ALU_Out, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("reset.out", ALU_Out, 8'h00);
            check("reset.cout", {7'd0, Cout}, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(8'h01, 8'h01, 4'd0, 8'h02, 1'b0, "post_reset");

        for (int s = 0; s < 16; s++)
            apply(8'h0A, 8'h02, s[3:0], sweep_exp[s], 1'b0, $sformatf("sweep%0d", s));

        apply(8'hF6, 8'h0A, 4'd0,  8'h00, 1'b1, "ovf_add");
        apply(8'hF6, 8'h0A, 4'd6,  8'hED, 1'b1, "ovf_rotl");
        apply(8'hF6, 8'h0A, 4'd7,  8'h7B, 1'b1, "ovf_rotr");
        apply(8'hF6, 8'h0A, 4'd2,  8'h9C, 1'b1, "ovf_mul");
        apply(8'hF6, 8'h0A, 4'd14, 8'h01, 1'b1, "ovf_gt");

        apply(8'h02, 8'h0A, 4'd1,  8'hF8, 1'b0, "edge_sub");
        apply(8'h37, 8'h00, 4'd3,  8'hFF, 1'b0, "edge_div0");
        apply(8'h80, 8'h00, 4'd4,  8'h00, 1'b0, "edge_shl");
        apply(8'h01, 8'h00, 4'd5,  8'h00, 1'b0, "edge_shr");
        apply(8'h5A, 8'h5A, 4'd15, 8'h01, 1'b0, "edge_eq");
        apply(8'h5A, 8'h5A, 4'd14, 8'h00, 1'b0, "edge_gt");

        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 4'($urandom_range(0, 15));
            apply(ra, rb, rs, 8'(model_out(int'(ra), int'(rb), int'(rs))),
                  1'(model_cout(int'(ra), int'(rb))), $sformatf("rand%0d", n));
        end

        // Asynchronous reset between edges while the output is non-zero.
        apply(8'hF0, 8'h20, 4'd0, 8'h10, 1'b1, "pre_midreset");
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset.out", ALU_Out, 8'h00);
        check("midreset.cout", {7'd0, Cout}, 8'h00);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("midreset_hold.out", ALU_Out, 8'h00);
            check("midreset_hold.cout", {7'd0, Cout}, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(8'h33, 8'h0F, 4'd10, 8'h3C, 1'b0, "post_midreset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
